legv8_multicycle_control: RTL and testbench

//  Multicycle LEGv8 control unit: an FSM sequencing FETCH/DECODE/EXEC/MEM/WB per instruction.

---
 rtl/legv8_multicycle_control.sv | 183 ++++++++++++++++++
 tb/tb_legv8_multicycle_control.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/legv8_multicycle_control.sv
// Multicycle LEGv8 control unit: sequences FETCH/DECODE/EXEC/MEM/WB per instruction,
// handshakes with a variable-latency unified memory, and traps on illegal opcodes or memory timeouts.
module legv8_multicycle_control #(
    parameter int ALUOP_W     = 2,
    parameter int MEM_TIMEOUT = 15,
    parameter bit ENABLE_TRAP = 1'b1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [10:0]        opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic               ir_write,
    output logic               pc_write,
    output logic               pc_src,
    output logic               reg2loc,
    output logic               alu_src,
    output logic               mem_read,
    output logic               mem_to_reg,
    output logic               reg_write,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               instr_done,
    output logic               illegal_op,
    output logic               timeout
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP
    } ctrlState;

    typedef enum logic [3:0] {
        OP_B, OP_ADDI, OP_CBZ, OP_CBNZ, OP_LDUR, OP_STUR,
        OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_ILLEGAL
    } instrClass;

    // Short-form encodings are matched first so their don't-care bits never alias a full compare.
    function automatic instrClass classify(input logic [10:0] op);
        if (op[10:5] == 6'b000101)           return OP_B;
        else if (op[10:1] == 10'b1001000100) return OP_ADDI;
        else if (op[10:3] == 8'b10110100)    return OP_CBZ;
        else if (op[10:3] == 8'b10110101)    return OP_CBNZ;
        else begin
            case (op)
                11'b11111000010: return OP_LDUR;
                11'b11111000000: return OP_STUR;
                11'b10001011000: return OP_ADD;
                11'b11001011000: return OP_SUB;
                11'b10001010000: return OP_AND;
                11'b10101010000: return OP_ORR;
                default:         return OP_ILLEGAL;
            endcase
        end
    endfunction

    ctrlState        state;
    logic [10:0]     opLatched;
    logic [CNT_W-1:0] waitCnt;
    instrClass       liveClass;
    instrClass       heldClass;
    logic            waitLimit;

    assign liveClass = classify(opcode);
    assign heldClass = classify(opLatched);
    assign waitLimit = (waitCnt == CNT_W'(MEM_TIMEOUT));

    // NOTE: all state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            opLatched  <= '0;
            waitCnt    <= '0;
            illegal_op <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= FETCH;
                FETCH, MEM: begin
                    if (mem_ready) begin
                        waitCnt <= '0;
                        if (state == FETCH)             state <= DECODE;
                        else if (heldClass == OP_LDUR)  state <= WB;
                        else                            state <= FETCH;
                    end else if (waitLimit) begin
                        waitCnt <= '0;
                        timeout <= 1'b1;
                        state   <= TRAP;
                    end else begin
                        waitCnt <= waitCnt + CNT_W'(1);
                    end
                end
                DECODE: begin
                    opLatched <= opcode;
                    if (liveClass != OP_ILLEGAL) begin
                        state <= EXEC;
                    end else if (ENABLE_TRAP) begin
                        illegal_op <= 1'b1;
                        state      <= TRAP;
                    end else begin
                        state <= FETCH;
                    end
                end
                EXEC: begin
                    case (heldClass)
                        OP_B, OP_CBZ, OP_CBNZ: state <= FETCH;
                        OP_LDUR, OP_STUR:      state <= MEM;
                        default:               state <= WB;
                    endcase
                end
                WB:      state <= FETCH;
                TRAP:    state <= TRAP;
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: every output is defaulted first so no state path can leave one unassigned and infer a latch.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg2loc    = 1'b0;
        alu_src    = 1'b0;
        mem_read   = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_op     = '0;
        instr_done = 1'b0;
        case (state)
            FETCH: begin
                mem_req  = 1'b1;
                mem_read = 1'b1;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            DECODE: instr_done = (liveClass == OP_ILLEGAL) && !ENABLE_TRAP;
            EXEC: begin
                case (heldClass)
                    OP_B: begin
                        pc_write   = 1'b1;
                        pc_src     = 1'b1;
                        instr_done = 1'b1;
                    end
                    OP_CBZ, OP_CBNZ: begin
                        reg2loc    = 1'b1;
                        alu_op     = ALUOP_W'(2'b01);
                        pc_write   = (heldClass == OP_CBZ) ? zero : !zero;
                        pc_src     = pc_write;
                        instr_done = 1'b1;
                    end
                    OP_ADDI:                alu_src = 1'b1;
                    OP_SUB, OP_AND, OP_ORR: alu_op  = ALUOP_W'(2'b10);
                    OP_LDUR:                alu_src = 1'b1;
                    OP_STUR: begin
                        alu_src = 1'b1;
                        reg2loc = 1'b1;
                    end
                    default: ;
                endcase
            end
            MEM: begin
                mem_req    = 1'b1;
                alu_src    = 1'b1;
                mem_read   = (heldClass == OP_LDUR);
                mem_we     = (heldClass == OP_STUR);
                reg2loc    = (heldClass == OP_STUR);
                instr_done = (heldClass == OP_STUR) && mem_ready;
            end
            WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (heldClass == OP_LDUR);
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_legv8_multicycle_control.sv
// Directed bench for legv8_multicycle_control: per-cycle control vectors checked against hand-derived tables,
// with a second instance built with the illegal-opcode trap disabled.
module tb_legv8_multicycle_control;

    localparam logic [14:0] MREQ = 15'h4000, MWE  = 15'h2000, IRW  = 15'h1000, PCW  = 15'h0800;
    localparam logic [14:0] PCS  = 15'h0400, R2L  = 15'h0200, ASRC = 15'h0100, MRD  = 15'h0080;
    localparam logic [14:0] M2R  = 15'h0040, RW   = 15'h0020, AOP1 = 15'h0010, AOP0 = 15'h0008;
    localparam logic [14:0] DONE = 15'h0004, ILL  = 15'h0002, TOUT = 15'h0001;
    localparam logic [14:0] F_RDY  = MREQ | MRD | IRW | PCW;
    localparam logic [14:0] F_WAIT = MREQ | MRD;
    localparam logic [14:0] CB     = R2L | AOP0;

    localparam logic [10:0] OP_ADD  = 11'h458, OP_SUB = 11'h658, OP_AND = 11'h450, OP_ORR = 11'h550;
    localparam logic [10:0] OP_LDUR = 11'h7C2, OP_STUR = 11'h7C0, OP_ADDI = 11'h489;
    localparam logic [10:0] OP_CBZ  = 11'h5A0, OP_CBNZ = 11'h5A8, OP_B0 = 11'h0A0, OP_B1 = 11'h0BF;

    logic        clock, reset_n, zero, mem_ready;
    logic [10:0] opcode;
    logic        mem_req, mem_we, ir_write, pc_write, pc_src, reg2loc, alu_src, mem_read;
    logic        mem_to_reg, reg_write, instr_done, illegal_op, timeout;
    logic [1:0]  alu_op;
    logic        ntMemReq, ntMemWe, ntIrWrite, ntPcWrite, ntPcSrc, ntReg2loc, ntAluSrc, ntMemRead;
    logic        ntMemToReg, ntRegWrite, ntInstrDone, ntIllegalOp, ntTimeout;
    logic [1:0]  ntAluOp;
    logic [14:0] obs, obsNt;
    int          nCompared = 0;
    int          nMismatched = 0;

    assign obs = {mem_req, mem_we, ir_write, pc_write, pc_src, reg2loc, alu_src, mem_read,
                  mem_to_reg, reg_write, alu_op, instr_done, illegal_op, timeout};
    assign obsNt = {ntMemReq, ntMemWe, ntIrWrite, ntPcWrite, ntPcSrc, ntReg2loc, ntAluSrc, ntMemRead,
                    ntMemToReg, ntRegWrite, ntAluOp, ntInstrDone, ntIllegalOp, ntTimeout};

    legv8_multicycle_control #(.ALUOP_W(2), .MEM_TIMEOUT(15), .ENABLE_TRAP(1'b1)) dut (
        .clock(clock), .reset_n(reset_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .reg2loc(reg2loc), .alu_src(alu_src), .mem_read(mem_read), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_op(alu_op), .instr_done(instr_done), .illegal_op(illegal_op),
        .timeout(timeout)
    );

    legv8_multicycle_control #(.ALUOP_W(2), .MEM_TIMEOUT(15), .ENABLE_TRAP(1'b0)) dutNoTrap (
        .clock(clock), .reset_n(reset_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(ntMemReq), .mem_we(ntMemWe), .ir_write(ntIrWrite), .pc_write(ntPcWrite),
        .pc_src(ntPcSrc), .reg2loc(ntReg2loc), .alu_src(ntAluSrc), .mem_read(ntMemRead),
        .mem_to_reg(ntMemToReg), .reg_write(ntRegWrite), .alu_op(ntAluOp), .instr_done(ntInstrDone),
        .illegal_op(ntIllegalOp), .timeout(ntTimeout)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Leaves the bench 1 time unit into cycle 1 (IDLE) after reset release.
    task automatic applyReset();
        reset_n   = 1'b0;
        mem_ready = 1'b0;
        zero      = 1'b0;
        opcode    = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        mem_ready = 1'b1;
        zero      = 1'b1;
        opcode    = OP_ADD;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #2;
            nCompared++;
            if (obs !== 15'h0) begin
                nMismatched++;
                $display("FAIL reset_hold[%0d]: got %h want %h", i, obs, 15'h0);
            end
        end
        @(negedge clock);
        reset_n = 1'b1;
        #2;
        nCompared++;
        if (obs !== 15'h0) begin
            nMismatched++;
            $display("FAIL reset_idle: got %h want %h", obs, 15'h0);
        end
        tick();
        #1;
        nCompared++;
        if (obs !== F_RDY) begin
            nMismatched++;
            $display("FAIL reset_first_fetch: got %h want %h", obs, F_RDY);
        end
    endtask

    task automatic test_add();
        logic [14:0] want [6] = '{15'h0, F_RDY, 15'h0, 15'h0, RW | DONE, F_RDY};
        applyReset();
        opcode    = OP_ADD;
        mem_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) tick();
            #1;
            nCompared++;
            if (obs !== want[c]) begin
                nMismatched++;
                $display("FAIL add_cycle%0d: got %h want %h", c + 1, obs, want[c]);
            end
        end
    endtask

    task automatic test_ldur_wait();
        localparam logic [14:0] LM = MREQ | MRD | ASRC;
        logic        rdy  [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [14:0] want [10] = '{15'h0, F_RDY, 15'h0, ASRC, LM, LM, LM, LM, RW | M2R | DONE, F_RDY};
        applyReset();
        for (int c = 0; c < 10; c++) begin
            if (c > 0) tick();
            mem_ready = rdy[c];
            opcode    = (c <= 2) ? OP_LDUR : 11'h7FF;
            #1;
            nCompared++;
            if (obs !== want[c]) begin
                nMismatched++;
                $display("FAIL ldur_cycle%0d: got %h want %h", c + 1, obs, want[c]);
            end
        end
    endtask

    task automatic test_branches();
        logic [10:0] ops  [6] = '{OP_CBZ, OP_CBZ, OP_CBNZ, OP_CBNZ, OP_B0, OP_B1};
        logic        zs   [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [14:0] want [6] = '{CB | PCW | PCS | DONE, CB | DONE, CB | PCW | PCS | DONE, CB | DONE,
                                  PCW | PCS | DONE, PCW | PCS | DONE};
        applyReset();
        mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            opcode = ops[i];
            zero   = 1'b0;
            #1;
            nCompared++;
            if (obs !== F_RDY) begin
                nMismatched++;
                $display("FAIL branch%0d_fetch: got %h want %h", i, obs, F_RDY);
            end
            tick();
            #1;
            nCompared++;
            if (obs !== 15'h0) begin
                nMismatched++;
                $display("FAIL branch%0d_decode: got %h want %h", i, obs, 15'h0);
            end
            tick();
            zero = zs[i];
            #1;
            nCompared++;
            if (obs !== want[i]) begin
                nMismatched++;
                $display("FAIL branch%0d_exec: got %h want %h", i, obs, want[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] ops   [6] = '{OP_ADDI, OP_SUB, OP_STUR, OP_AND, OP_ORR, OP_ADD};
        logic [14:0] wantE [6] = '{ASRC, AOP1, ASRC | R2L, AOP1, AOP1, 15'h0};
        logic [14:0] wantL [6] = '{RW | DONE, RW | DONE, MREQ | MWE | R2L | ASRC | DONE,
                                   RW | DONE, RW | DONE, RW | DONE};
        applyReset();
        mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            opcode = ops[i];
            #1;
            nCompared++;
            if (obs !== F_RDY) begin
                nMismatched++;
                $display("FAIL b2b%0d_fetch: got %h want %h", i, obs, F_RDY);
            end
            tick();
            tick();
            #1;
            nCompared++;
            if (obs !== wantE[i]) begin
                nMismatched++;
                $display("FAIL b2b%0d_exec: got %h want %h", i, obs, wantE[i]);
            end
            tick();
            #1;
            nCompared++;
            if (obs !== wantL[i]) begin
                nMismatched++;
                $display("FAIL b2b%0d_last: got %h want %h", i, obs, wantL[i]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [10:0] bad [2] = '{11'h7FF, 11'h459};
        for (int i = 0; i < 2; i++) begin
            applyReset();
            mem_ready = 1'b1;
            opcode    = bad[i];
            tick();
            tick();
            #1;
            nCompared++;
            if (obs !== 15'h0 || obsNt !== DONE) begin
                nMismatched++;
                $display("FAIL illegal%0d_decode: got %h/%h want %h/%h", i, obs, obsNt, 15'h0, DONE);
            end
            tick();
            #1;
            nCompared++;
            if (obsNt !== F_RDY) begin
                nMismatched++;
                $display("FAIL illegal%0d_nop_fetch: got %h want %h", i, obsNt, F_RDY);
            end
            for (int k = 0; k < 4; k++) begin
                if (k > 0) tick();
                #1;
                nCompared++;
                if (obs !== ILL) begin
                    nMismatched++;
                    $display("FAIL illegal%0d_trap%0d: got %h want %h", i, k, obs, ILL);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int readyAt [2] = '{15, 16};
        applyReset();
        opcode = OP_ADD;
        for (int k = 1; k <= 16; k++) begin
            tick();
            #1;
            nCompared++;
            if (obs !== F_WAIT) begin
                nMismatched++;
                $display("FAIL timeout_wait%0d: got %h want %h", k, obs, F_WAIT);
            end
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            mem_ready = (k > 0);
            #1;
            nCompared++;
            if (obs !== TOUT) begin
                nMismatched++;
                $display("FAIL timeout_trap%0d: got %h want %h", k, obs, TOUT);
            end
        end
        for (int i = 0; i < 2; i++) begin
            applyReset();
            opcode = OP_ADD;
            for (int k = 1; k <= readyAt[i]; k++) begin
                tick();
                mem_ready = (k == readyAt[i]);
                #1;
                nCompared++;
                if (obs !== ((k == readyAt[i]) ? F_RDY : F_WAIT)) begin
                    nMismatched++;
                    $display("FAIL late_ready%0d_cycle%0d: got %h want %h", readyAt[i], k, obs,
                             (k == readyAt[i]) ? F_RDY : F_WAIT);
                end
            end
            tick();
            mem_ready = 1'b0;
            #1;
            nCompared++;
            if (obs !== 15'h0) begin
                nMismatched++;
                $display("FAIL late_ready%0d_decode: got %h want %h", readyAt[i], obs, 15'h0);
            end
        end
    endtask

    task automatic test_reset_mid_mem();
        applyReset();
        opcode    = OP_STUR;
        mem_ready = 1'b1;
        tick();
        tick();
        tick();
        #1;
        nCompared++;
        if (obs !== (ASRC | R2L)) begin
            nMismatched++;
            $display("FAIL stur_exec: got %h want %h", obs, ASRC | R2L);
        end
        tick();
        mem_ready = 1'b0;
        #1;
        nCompared++;
        if (obs !== (MREQ | MWE | R2L | ASRC)) begin
            nMismatched++;
            $display("FAIL stur_mem_wait: got %h want %h", obs, MREQ | MWE | R2L | ASRC);
        end
        #2;
        reset_n = 1'b0;
        #1;
        nCompared++;
        if (obs !== 15'h0) begin
            nMismatched++;
            $display("FAIL async_reset_drop: got %h want %h", obs, 15'h0);
        end
        @(posedge clock);
        @(negedge clock);
        reset_n   = 1'b1;
        mem_ready = 1'b1;
        #2;
        nCompared++;
        if (obs !== 15'h0) begin
            nMismatched++;
            $display("FAIL restart_idle: got %h want %h", obs, 15'h0);
        end
        tick();
        #1;
        nCompared++;
        if (obs !== F_RDY) begin
            nMismatched++;
            $display("FAIL restart_fetch: got %h want %h", obs, F_RDY);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        mem_ready = 1'b0;
        zero      = 1'b0;
        opcode    = '0;
        test_reset();
        test_add();
        test_ldur_wait();
        test_branches();
        test_back_to_back();
        test_illegal();
        test_timeout();
        test_reset_mid_mem();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
